frame_beat_packer: RTL and testbench

FRAME_BEAT_PACKER -- requirements
Module: frame_beat_packer

---
 rtl/frame_beat_packer_if.sv | 13 +
 rtl/frame_beat_packer.sv | 118 +++++++++++
 tb/tb_frame_beat_packer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_beat_packer_if.sv
// AXI-stream style handshake bundle shared by the narrow input and wide output sides
// of frame_beat_packer.
interface frame_beat_packer_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/frame_beat_packer.sv
// Packs R narrow pixel beats into one wide beat, tracks frame boundaries and framing errors.
// Optional FRAME_PACKER_RESYNC_EN: an early input tlast closes the frame with a zero-padded word.
module frame_beat_packer #(
    parameter int IN_PIXELS       = 8,
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 64
) (
    input  logic                s_axis_aclk,
    input  logic                s_axis_areset,
    frame_beat_packer_if.slave  s_axis,
    frame_beat_packer_if.master m_axis,
    output logic [15:0]         frame_count,
    output logic                err_early,
    output logic                err_missing
);
    localparam int IN_W  = 8 * IN_PIXELS;
    localparam int OUT_W = 8 * PIXELS_PER_BEAT;
    localparam int R     = PIXELS_PER_BEAT / IN_PIXELS;
    localparam int IB    = IMAGE_DIM * IMAGE_DIM / IN_PIXELS;
    localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
    localparam int IB_W  = (IB > 1) ? $clog2(IB) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(R - 1);
    localparam logic [IB_W-1:0]  IB_LAST  = IB_W'(IB - 1);

    logic [IDX_W-1:0] idx;
    logic [IB_W-1:0]  ibeat;
    logic [OUT_W-1:0] pack_q;
    logic [OUT_W-1:0] load_word;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             idx_last;
    logic             ibeat_last;
    logic             early_last;
    logic             flush;
    logic             accept;
    logic             emit;

    assign idx_last   = (idx == IDX_LAST);
    assign ibeat_last = (ibeat == IB_LAST);
    assign early_last = s_axis.tlast & ~ibeat_last;

`ifdef FRAME_PACKER_RESYNC_EN
    // An early tlast closes the current word, so it needs the output slot just like slot R-1.
    assign flush = early_last;
`else
    assign flush = 1'b0;
`endif

    assign s_axis.tready = (~idx_last & ~flush) | ~out_valid | m_axis.tready;
    assign accept        = s_axis.tvalid & s_axis.tready;
    assign emit          = accept & (idx_last | flush);

    assign m_axis.tdata  = out_data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;

    // Word as it would look if closed this cycle: earlier slots from pack_q, current beat
    // in slot idx, zeros above it.
    always_comb begin
        // NOTE: default assignment first so every path writes load_word and no latch is inferred.
        load_word = pack_q;
        for (int k = 0; k < R; k++) begin
            if (k == int'(idx)) begin
                load_word[k*IN_W +: IN_W] = s_axis.tdata;
            end else if (k > int'(idx)) begin
                load_word[k*IN_W +: IN_W] = '0;
            end
        end
    end

    // NOTE: pack_q is pure datapath with no reset; slots are always written before idx
    // advances past them, so stale contents are never observed.
    always_ff @(posedge s_axis_aclk) begin
        if (accept) begin
            pack_q[int'(idx)*IN_W +: IN_W] <= s_axis.tdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            idx         <= '0;
            ibeat       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_count <= '0;
            err_early   <= 1'b0;
            err_missing <= 1'b0;
        end else begin
            if (accept) begin
                idx   <= emit ? '0 : idx + 1'b1;
                ibeat <= (ibeat_last | flush) ? '0 : ibeat + 1'b1;
                if (early_last) begin
                    err_early <= 1'b1;
                end
                if (ibeat_last & ~s_axis.tlast) begin
                    err_missing <= 1'b1;
                end
            end

            if (emit) begin
                out_data  <= load_word;
                out_valid <= 1'b1;
                out_last  <= ibeat_last | flush;
            end else if (m_axis.tready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (out_valid & m_axis.tready & out_last) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_frame_beat_packer.sv
// Directed self-checking bench for frame_beat_packer at default parameters (R=2, 512 beats/frame).
module tb_frame_beat_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] frame_count;
    logic        err_early;
    logic        err_missing;

    int n_assert   = 0;
    int n_fail     = 0;
    int mon_count  = 0;
    int mon_base   = 0;
    int mon_lasts  = 0;
    int stall_cnt  = 0;
    bit mon_chk    = 1'b0;
    bit sampled_ready;

    frame_beat_packer_if #(.DATA_W(64))  s_if();
    frame_beat_packer_if #(.DATA_W(128)) m_if();

    frame_beat_packer dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .frame_count   (frame_count),
        .err_early     (err_early),
        .err_missing   (err_missing)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] bd(input int n);
        logic [15:0] v;
        v  = n[15:0];
        bd = {16'hA5C3, v, 16'h5A5A ^ v, 16'(v * 7)};
    endfunction

    // One clock: observe handshakes at the falling edge, return just after the rising edge.
    task automatic tick();
        int            k;
        logic [127:0]  exp_w;
        logic          exp_l;
        @(negedge clk);
        sampled_ready = s_if.tready;
        if (!rst && m_if.tvalid && m_if.tready) begin
            if (mon_chk) begin
                k     = mon_count - mon_base;
                exp_w = {bd(2*k + 1), bd(2*k)};
                exp_l = ((k % 256) == 255);
                n_assert++;
                if (m_if.tdata !== exp_w) begin
                    n_fail++;
                    $display("FAIL out_data[%0d] got %h want %h", k, m_if.tdata, exp_w);
                end
                n_assert++;
                if (m_if.tlast !== exp_l) begin
                    n_fail++;
                    $display("FAIL out_last[%0d] got %b want %b", k, m_if.tlast, exp_l);
                end
            end
            mon_count++;
            if (m_if.tlast) mon_lasts++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        int waited;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        waited      = 0;
        do begin
            tick();
            if (!sampled_ready) begin
                waited++;
                stall_cnt++;
            end
        end while (!sampled_ready && waited < 100);
        if (!sampled_ready) begin
            n_assert++;
            n_fail++;
            $display("FAIL send_timeout data %h never accepted", d);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input int tl_a, input int tl_b);
        for (int n = first; n <= last; n++) begin
            send(bd(n), (n == tl_a) || (n == tl_b));
        end
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        mon_chk     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        #1;
        n_assert++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b want 0", m_if.tvalid); end
        n_assert++; if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b want 0", m_if.tlast); end
        n_assert++; if (m_if.tdata !== '0) begin n_fail++; $display("FAIL rst_tdata got %h want 0", m_if.tdata); end
        n_assert++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_frame_count got %0d want 0", frame_count); end
        n_assert++; if (err_early !== 1'b0) begin n_fail++; $display("FAIL rst_err_early got %b want 0", err_early); end
        n_assert++; if (err_missing !== 1'b0) begin n_fail++; $display("FAIL rst_err_missing got %b want 0", err_missing); end
        n_assert++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL rst_s_tready got %b want 1", s_if.tready); end
        apply_reset();
    endtask

    task automatic test_pack();
        apply_reset();
        m_if.tready = 1'b1;
        send(64'h0706050403020100, 1'b0);
        n_assert++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL pack_half_valid got %b want 0", m_if.tvalid); end
        send(64'h0F0E0D0C0B0A0908, 1'b0);
        n_assert++; if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL pack_valid got %b want 1", m_if.tvalid); end
        n_assert++;
        if (m_if.tdata !== 128'h0F0E0D0C0B0A09080706050403020100) begin
            n_fail++;
            $display("FAIL pack_data got %h want 0f0e0d0c0b0a09080706050403020100", m_if.tdata);
        end
        tick();
        n_assert++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL pack_drain_valid got %b want 0", m_if.tvalid); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mon_base = mon_count;
        mon_chk  = 1'b1;
        send_range(0, 2, -1, -1);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_assert++; if (sampled_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_tready[%0d] got %b want 0", i, sampled_ready); end
            n_assert++; if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, m_if.tvalid); end
            n_assert++;
            if (m_if.tdata !== {bd(1), bd(0)}) begin
                n_fail++;
                $display("FAIL bp_hold_data[%0d] got %h want %h", i, m_if.tdata, {bd(1), bd(0)});
            end
        end
        m_if.tready = 1'b1;
        stall_cnt   = 0;
        send_range(3, 22, -1, -1);
        n_assert++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL bp_stalls got %0d want 0", stall_cnt); end
        n_assert++; if (mon_count - mon_base !== 11) begin n_fail++; $display("FAIL bp_out_count got %0d want 11", mon_count - mon_base); end
    endtask

    task automatic test_full_frame();
        int lasts0;
        apply_reset();
        m_if.tready = 1'b1;
        mon_base    = mon_count;
        lasts0      = mon_lasts;
        mon_chk     = 1'b1;
        send_range(0, 511, 511, -1);
        tick();
        tick();
        n_assert++; if (mon_count - mon_base !== 256) begin n_fail++; $display("FAIL ff_out_count got %0d want 256", mon_count - mon_base); end
        n_assert++; if (mon_lasts - lasts0 !== 1) begin n_fail++; $display("FAIL ff_lasts got %0d want 1", mon_lasts - lasts0); end
        n_assert++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL ff_frame_count got %0d want 1", frame_count); end
        n_assert++; if (err_early !== 1'b0) begin n_fail++; $display("FAIL ff_err_early got %b want 0", err_early); end
        n_assert++; if (err_missing !== 1'b0) begin n_fail++; $display("FAIL ff_err_missing got %b want 0", err_missing); end
    endtask

    task automatic test_early_tlast();
        int lasts0;
        apply_reset();
        m_if.tready = 1'b1;
        mon_base    = mon_count;
        lasts0      = mon_lasts;
`ifdef FRAME_PACKER_RESYNC_EN
        send_range(0, 99, -1, -1);
        send(bd(100), 1'b1);
        n_assert++; if (err_early !== 1'b1) begin n_fail++; $display("FAIL early_err got %b want 1", err_early); end
        n_assert++; if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL early_valid got %b want 1", m_if.tvalid); end
        n_assert++; if (m_if.tlast !== 1'b1) begin n_fail++; $display("FAIL early_tlast got %b want 1", m_if.tlast); end
        n_assert++;
        if (m_if.tdata !== {64'h0, bd(100)}) begin
            n_fail++;
            $display("FAIL early_pad_data got %h want %h", m_if.tdata, {64'h0, bd(100)});
        end
        tick();
        n_assert++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL early_frame_count got %0d want 1", frame_count); end
`else
        mon_chk = 1'b1;
        send_range(0, 100, 100, -1);
        n_assert++; if (err_early !== 1'b1) begin n_fail++; $display("FAIL early_err got %b want 1", err_early); end
        tick();
        tick();
        n_assert++; if (mon_lasts - lasts0 !== 0) begin n_fail++; $display("FAIL early_no_tlast got %0d want 0", mon_lasts - lasts0); end
        send_range(101, 511, 511, -1);
        tick();
        tick();
        n_assert++; if (mon_lasts - lasts0 !== 1) begin n_fail++; $display("FAIL early_lasts got %0d want 1", mon_lasts - lasts0); end
        n_assert++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL early_frame_count got %0d want 1", frame_count); end
        n_assert++; if (err_missing !== 1'b0) begin n_fail++; $display("FAIL early_err_missing got %b want 0", err_missing); end
`endif
    endtask

    task automatic test_missing_tlast();
        int lasts0;
        apply_reset();
        m_if.tready = 1'b1;
        mon_base    = mon_count;
        lasts0      = mon_lasts;
        mon_chk     = 1'b1;
        send_range(0, 511, -1, -1);
        n_assert++; if (err_missing !== 1'b1) begin n_fail++; $display("FAIL miss_err got %b want 1", err_missing); end
        n_assert++; if (err_early !== 1'b0) begin n_fail++; $display("FAIL miss_err_early got %b want 0", err_early); end
        send_range(512, 1023, 1023, -1);
        tick();
        tick();
        n_assert++; if (mon_count - mon_base !== 512) begin n_fail++; $display("FAIL miss_out_count got %0d want 512", mon_count - mon_base); end
        n_assert++; if (mon_lasts - lasts0 !== 2) begin n_fail++; $display("FAIL miss_lasts got %0d want 2", mon_lasts - lasts0); end
        n_assert++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL miss_frame_count got %0d want 2", frame_count); end
        n_assert++; if (err_missing !== 1'b1) begin n_fail++; $display("FAIL miss_sticky got %b want 1", err_missing); end
    endtask

    task automatic test_reset_mid_frame();
        int lasts0;
        apply_reset();
        send(bd(0), 1'b0);
        send(bd(1), 1'b1);
        send(bd(2), 1'b0);
        n_assert++; if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", m_if.tvalid); end
        n_assert++; if (err_early !== 1'b1) begin n_fail++; $display("FAIL mid_pre_err got %b want 1", err_early); end
        #3;
        rst = 1'b1;
        #1;
        n_assert++; if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid got %b want 0", m_if.tvalid); end
        n_assert++; if (m_if.tlast !== 1'b0) begin n_fail++; $display("FAIL mid_tlast got %b want 0", m_if.tlast); end
        n_assert++; if (m_if.tdata !== '0) begin n_fail++; $display("FAIL mid_tdata got %h want 0", m_if.tdata); end
        n_assert++; if (err_early !== 1'b0) begin n_fail++; $display("FAIL mid_err_early got %b want 0", err_early); end
        n_assert++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL mid_s_tready got %b want 1", s_if.tready); end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        m_if.tready = 1'b1;
        mon_base    = mon_count;
        lasts0      = mon_lasts;
        mon_chk     = 1'b1;
        send_range(0, 511, 511, -1);
        tick();
        tick();
        n_assert++; if (mon_count - mon_base !== 256) begin n_fail++; $display("FAIL mid_out_count got %0d want 256", mon_count - mon_base); end
        n_assert++; if (mon_lasts - lasts0 !== 1) begin n_fail++; $display("FAIL mid_lasts got %0d want 1", mon_lasts - lasts0); end
        n_assert++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL mid_frame_count got %0d want 1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_backpressure();
        test_full_frame();
        test_early_tlast();
        test_missing_tlast();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
